seq_arith_unit: RTL and testbench

SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

---
 rtl/seq_arith_unit.sv | 102 ++++++++++
 tb/tb_seq_arith_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_arith_unit.sv
// Sequential arithmetic unit: registers op_a+op_b on accept, then forms op_a*op_b
// with a fixed-length shift-and-add loop and holds both until consumed downstream.
module seq_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       sum,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [7:0]           op_count
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CNT_W-1:0]     iter;

  // Partial product for the current multiplier bit; also feeds the final product load.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      iter      <= '0;
      sum       <= '0;
      product   <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= {{WIDTH{1'b0}}, op_a};
            mplier   <= op_b;
            acc      <= '0;
            iter     <= '0;
            sum      <= {1'b0, op_a} + {1'b0, op_b};
            state    <= MUL;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          iter   <= iter + CNT_W'(1);
          // Always WIDTH iterations, so latency never depends on operand values.
          if (iter == LAST_ITER) begin
            product   <= acc_next;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            op_count  <= op_count + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit: cycle-level behavioural model plus literal checks.
module tb_seq_arith_unit;

  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     op_a = '0;
  logic [W-1:0]     op_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W:0]       sum;
  logic [2*W-1:0]   product;
  logic             busy;
  logic [7:0]       op_count;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .product(product), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting for operands, 1 = computing until deadline, 2 = holding result.
  int phase, cyc, due, m_sum, m_pend, m_prod, m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0; cyc <= 0; due <= 0;
      m_sum <= 0; m_pend <= 0; m_prod <= 0; m_count <= 0;
    end else begin
      cyc <= cyc + 1;
      case (phase)
        0: if (in_valid) begin
             m_sum  <= int'(op_a) + int'(op_b);
             m_pend <= int'(op_a) * int'(op_b);
             due    <= cyc + W;
             phase  <= 1;
           end
        1: if (cyc == due) begin
             m_prod <= m_pend;
             phase  <= 2;
           end
        default: if (out_ready) begin
             phase   <= 0;
             m_count <= (m_count + 1) % 256;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready",  in_ready,  phase == 0);
      chk("busy",      busy,      phase == 1);
      chk("out_valid", out_valid, phase == 2);
      chk("sum",       sum,       m_sum);
      chk("product",   product,   m_prod);
      chk("op_count",  op_count,  m_count);
    end
  end

  // One transaction; hold>0 keeps out_ready low that many cycles in DONE while poking in_valid.
  task automatic run(input int a, input int b, input int hold, input bit lit,
                     input int exp_s, input int exp_p);
    int n;
    out_ready = (hold == 0);
    in_valid = 1'b1; op_a = W'(a); op_b = W'(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, W);
    if (lit) begin
      chk("lit_sum", sum, exp_s);
      chk("lit_product", product, exp_p);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      if (lit) begin
        chk("hold_sum", sum, exp_s);
        chk("hold_product", product, exp_p);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_idle", in_ready, 1);
  endtask

  initial begin
    int a, b;
    @(posedge clk); #1;
    started = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(10, 99, 0, 1, 109, 990);
    chk("count_after_first", op_count, 1);
    run(132, 33, 0, 1, 165, 4356);
    run(4, 33, 0, 1, 37, 132);
    chk("count_after_pair", op_count, 3);
    run(255, 255, 0, 1, 510, 65025);
    run(0, 34, 0, 1, 34, 0);
    run(77, 3, 5, 1, 80, 231);
    chk("count_before_reset", op_count, 6);

    // Reset in the middle of a multiply, away from any clock edge.
    in_valid = 1'b1; op_a = 8'd200; op_b = 8'd150;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_sum", sum, 0);
    chk("arst_product", product, 0);
    chk("arst_op_count", op_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(3, 5, 0, 1, 8, 15);
    chk("count_after_reset", op_count, 1);

    for (int t = 0; t < 255; t++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      run(a, b, 0, 1, a + b, a * b);
    end
    chk("count_wrap", op_count, 0);

    started = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete at %0t", $time);
    $fatal(1);
  end

endmodule
